// File: rtl/pc_return_stack_pkg.sv
// rat_pkg: shared definitions for the return-address stack and its neighbours.
//   pc_src_t    - encoding of the PC_MUX_SEL next-address source select
//   PC_W        - program-memory address width
//   INTR_VECTOR - fixed interrupt entry address
package rat_pkg;

  localparam int unsigned PC_W = 10;
  localparam logic [PC_W-1:0] INTR_VECTOR = 10'h3FF;

  typedef enum logic [1:0] {
    PC_SRC_IMMED = 2'd0,
    PC_SRC_STACK = 2'd1,
    PC_SRC_INTR  = 2'd2,
    PC_SRC_RSVD  = 2'd3
  } pc_src_t;

endpackage

// File: rtl/pc_return_stack_mem.sv
// return_stack_mem: DEPTH x PC_W register array backing the return stack.
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - asynchronous read address
//   rdata - asynchronous read data
// Contents are intentionally not reset.
module return_stack_mem #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PC_W  = 10
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [PC_W-1:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [PC_W-1:0]          rdata
);

  logic [PC_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pc_return_stack.sv
// pc_return_stack: next-address selection for the program counter plus a
// hardware return-address LIFO for CALL/RET and interrupt entry.
//   CLK, RST    - clock, synchronous active-high reset
//   PC_COUNT    - current program-counter value (return address = PC_COUNT+1)
//   IMMED       - branch/call target
//   PC_MUX_SEL  - 0 immediate, 1 top of stack, 2 interrupt vector, 3 zero
//   PUSH, POP   - stack operations for this cycle (both = overwrite top)
//   PC_DIN      - combinational address to the program counter
//   EMPTY, FULL, DEPTH_CNT - occupancy, derived from the stack pointer only
//   OVF_ERR, UNF_ERR       - sticky overflow / underflow flags
module pc_return_stack
  import rat_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PC_W  = rat_pkg::PC_W
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [PC_W-1:0]            PC_COUNT,
  input  logic [PC_W-1:0]            IMMED,
  input  logic [1:0]                 PC_MUX_SEL,
  input  logic                       PUSH,
  input  logic                       POP,
  output logic [PC_W-1:0]            PC_DIN,
  output logic                       EMPTY,
  output logic                       FULL,
  output logic [$clog2(DEPTH+1)-1:0] DEPTH_CNT,
  output logic                       OVF_ERR,
  output logic                       UNF_ERR
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned AW    = $clog2(DEPTH);

  logic [CNT_W-1:0] sp;
  logic [CNT_W-1:0] sp_next;
  logic             ovf;
  logic             unf;
  logic             ovf_set;
  logic             unf_set;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    top_addr;
  logic [PC_W-1:0]  ret_addr;
  logic [PC_W-1:0]  top_data;
  pc_src_t          src;

  assign EMPTY     = (sp == '0);
  assign FULL      = (sp == CNT_W'(DEPTH));
  assign DEPTH_CNT = sp;
  assign OVF_ERR   = ovf;
  assign UNF_ERR   = unf;

  // sp counts valid entries, so the top lives one below it.
  assign top_addr = AW'(sp - CNT_W'(1));
  // Natural PC_W-bit wrap gives 0x3FF + 1 = 0x000.
  assign ret_addr = PC_COUNT + PC_W'(1);

  always_comb begin
    we      = 1'b0;
    waddr   = AW'(sp);
    sp_next = sp;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    unique case ({PUSH, POP})
      2'b11: begin
        if (EMPTY) begin
          // Nothing to return from: degrade to a plain push, flag underflow.
          we      = 1'b1;
          sp_next = sp + CNT_W'(1);
          unf_set = 1'b1;
        end else begin
          // Return-and-call: replace the top entry in place.
          we    = 1'b1;
          waddr = top_addr;
        end
      end
      2'b10: begin
        if (FULL) begin
          ovf_set = 1'b1;
        end else begin
          we      = 1'b1;
          sp_next = sp + CNT_W'(1);
        end
      end
      2'b01: begin
        if (EMPTY) begin
          unf_set = 1'b1;
        end else begin
          sp_next = sp - CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sp  <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      sp  <= sp_next;
      ovf <= ovf | ovf_set;
      unf <= unf | unf_set;
    end
  end

  return_stack_mem #(
    .DEPTH (DEPTH),
    .PC_W  (PC_W)
  ) u_mem (
    .clk   (CLK),
    .we    (we & ~RST),
    .waddr (waddr),
    .wdata (ret_addr),
    .raddr (top_addr),
    .rdata (top_data)
  );

  assign src = pc_src_t'(PC_MUX_SEL);

  always_comb begin
    PC_DIN = '0;
    unique case (src)
      PC_SRC_IMMED: PC_DIN = IMMED;
      PC_SRC_STACK: PC_DIN = EMPTY ? '0 : top_data;
      PC_SRC_INTR:  PC_DIN = PC_W'(INTR_VECTOR);
      PC_SRC_RSVD:  PC_DIN = '0;
      default:      PC_DIN = '0;
    endcase
  end

endmodule

// File: tb/tb_pc_return_stack.sv
// tb_pc_return_stack: directed scenarios followed by random traffic, all
// checked against a queue-based LIFO model of the return stack.
module tb_pc_return_stack;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned PC_W  = 10;

  logic            clk;
  logic            rst;
  logic [PC_W-1:0] pc_count;
  logic [PC_W-1:0] immed;
  logic [1:0]      pc_mux_sel;
  logic            push;
  logic            pop;
  logic [PC_W-1:0] pc_din;
  logic            empty;
  logic            full;
  logic [3:0]      depth_cnt;
  logic            ovf_err;
  logic            unf_err;

  int checks;
  int errors;

  // Reference model state
  logic [PC_W-1:0] stk[$];
  logic            m_ovf;
  logic            m_unf;

  pc_return_stack #(
    .DEPTH (DEPTH),
    .PC_W  (PC_W)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .PC_COUNT   (pc_count),
    .IMMED      (immed),
    .PC_MUX_SEL (pc_mux_sel),
    .PUSH       (push),
    .POP        (pop),
    .PC_DIN     (pc_din),
    .EMPTY      (empty),
    .FULL       (full),
    .DEPTH_CNT  (depth_cnt),
    .OVF_ERR    (ovf_err),
    .UNF_ERR    (unf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [PC_W-1:0] model_pc_din(input logic [1:0] sel, input logic [PC_W-1:0] imm);
    case (sel)
      2'd0:    return imm;
      2'd1:    return (stk.size() == 0) ? 10'h000 : stk[$];
      2'd2:    return 10'h3FF;
      default: return 10'h000;
    endcase
  endfunction

  // One cycle: drive inputs, check the combinational view of the current
  // state, then advance the model across the clock edge.
  task automatic step(input logic r, input logic pu, input logic po,
                      input logic [1:0] sel, input logic [PC_W-1:0] pc,
                      input logic [PC_W-1:0] imm);
    logic [PC_W-1:0] ra;
    @(negedge clk);
    rst = r; push = pu; pop = po; pc_mux_sel = sel; pc_count = pc; immed = imm;
    #1;
    check_val("pc_din",    32'(pc_din),    32'(model_pc_din(sel, imm)));
    check_val("empty",     32'(empty),     32'(stk.size() == 0));
    check_val("full",      32'(full),      32'(stk.size() == DEPTH));
    check_val("depth_cnt", 32'(depth_cnt), 32'(stk.size()));
    check_val("ovf_err",   32'(ovf_err),   32'(m_ovf));
    check_val("unf_err",   32'(unf_err),   32'(m_unf));
    @(posedge clk);
    ra = pc + 10'd1;
    if (r) begin
      stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (pu && po) begin
      if (stk.size() == 0) begin
        stk.push_back(ra);
        m_unf = 1'b1;
      end else begin
        stk[stk.size()-1] = ra;
      end
    end else if (pu) begin
      if (stk.size() == DEPTH) m_ovf = 1'b1;
      else stk.push_back(ra);
    end else if (po) begin
      if (stk.size() == 0) m_unf = 1'b1;
      else void'(stk.pop_back());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    rst = 1'b1; push = 1'b0; pop = 1'b0; pc_mux_sel = 2'd0;
    pc_count = '0; immed = '0;
    repeat (2) @(posedge clk);

    // Reset state, stack select on an empty stack
    step(1'b0, 1'b0, 1'b0, 2'd1, 10'h000, 10'h000);

    // Call: immediate target while pushing PC+1
    step(1'b0, 1'b1, 1'b0, 2'd0, 10'h010, 10'h200);
    step(1'b0, 1'b0, 1'b0, 2'd1, 10'h000, 10'h000);
    step(1'b0, 1'b0, 1'b1, 2'd1, 10'h000, 10'h000);
    step(1'b0, 1'b0, 1'b0, 2'd1, 10'h000, 10'h000);

    // Return-address wrap
    step(1'b0, 1'b1, 1'b0, 2'd0, 10'h3FF, 10'h123);
    step(1'b0, 1'b0, 1'b1, 2'd1, 10'h000, 10'h000);

    // Fill, overflow, drain
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, 1'b0, 2'd1, 10'(i), 10'h000);
    step(1'b0, 1'b1, 1'b0, 2'd1, 10'h020, 10'h000);
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b0, 1'b1, 2'd1, 10'h000, 10'h000);

    // Return-and-call on a two-entry stack
    step(1'b1, 1'b0, 1'b0, 2'd0, 10'h000, 10'h000);
    step(1'b0, 1'b1, 1'b0, 2'd1, 10'h010, 10'h000);
    step(1'b0, 1'b1, 1'b0, 2'd1, 10'h054, 10'h000);
    step(1'b0, 1'b1, 1'b1, 2'd1, 10'h0AA, 10'h000);
    step(1'b0, 1'b0, 1'b0, 2'd1, 10'h000, 10'h000);

    // Underflow stickiness, push+pop on empty, reset beating a push
    step(1'b0, 1'b0, 1'b1, 2'd1, 10'h000, 10'h000);
    step(1'b0, 1'b0, 1'b1, 2'd1, 10'h000, 10'h000);
    step(1'b0, 1'b0, 1'b1, 2'd1, 10'h000, 10'h000);
    step(1'b0, 1'b1, 1'b1, 2'd1, 10'h033, 10'h000);
    step(1'b0, 1'b1, 1'b0, 2'd1, 10'h044, 10'h000);
    step(1'b1, 1'b1, 1'b0, 2'd1, 10'h100, 10'h000);
    step(1'b0, 1'b0, 1'b0, 2'd1, 10'h000, 10'h000);

    // Fixed sources
    step(1'b0, 1'b0, 1'b0, 2'd2, 10'h000, 10'h155);
    step(1'b0, 1'b0, 1'b0, 2'd3, 10'h000, 10'h155);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)),
           10'($urandom),
           10'($urandom));
    end

    step(1'b0, 1'b0, 1'b0, 2'd1, 10'h000, 10'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_return_stack.md
# pc_return_stack

Upstream companion of the program counter: selects the 10-bit address presented to the counter's load input and maintains a hardware return-address LIFO for CALL/RET and interrupt entry. It sits between the control unit and the program counter, driving the counter's DIN from one of three sources: immediate, top of stack, or interrupt vector. It also records return addresses from the current PC value.

## Interface
Parameters:
- DEPTH, 8, number of return-address entries (power of two, ≥2)
- PC_W, 10, address width (fixed by the program-memory size)

Ports:
- CLK  in  1  system clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- PC_COUNT  in  PC_W  current program-counter value
- IMMED  in  PC_W  branch/call target from the instruction word
- PC_MUX_SEL  in  2  next-address source: 0 immediate, 1 stack, 2 interrupt vector, 3 reserved
- PUSH  in  1  push return address this cycle
- POP  in  1  pop top entry this cycle
- PC_DIN  out  PC_W  address to the program counter's DIN
- EMPTY  out  1  no valid entries
- FULL  out  1  DEPTH valid entries
- DEPTH_CNT  out  $clog2(DEPTH+1)  valid-entry count
- OVF_ERR  out  1  sticky: push attempted while full
- UNF_ERR  out  1  sticky: pop attempted while empty

## Operation
- Return address pushed = (PC_COUNT + 1) mod 2^PC_W; 0x3FF wraps to 0x000.
- PC_DIN is combinational:
  - sel 0 → IMMED
  - sel 1 → current top-of-stack, or 0x000 when EMPTY
  - sel 2 → 0x3FF
  - sel 3 → 0x000
- Push only, not FULL: write entry at SP, SP+1.
- Push only, FULL: no write, SP unchanged, OVF_ERR set.
- Pop only, not EMPTY: SP−1; PC_DIN in the same cycle already shows the popped value.
- Pop only, EMPTY: SP unchanged, UNF_ERR set.
- Push and pop in the same cycle (return-and-call), not EMPTY: overwrite the top entry with the new return address, SP unchanged. PC_DIN shows the old top during that cycle.
- Push and pop in the same cycle, EMPTY: acts as a push; UNF_ERR set.
- Error flags are sticky until RST.
- EMPTY, FULL and DEPTH_CNT are derived from SP only.

## Timing
- PC_DIN has zero latency from PC_MUX_SEL, IMMED and the stack contents. The program counter captures it on the same edge that updates SP.
- A pushed entry is readable via sel 1 from the next cycle.
- Reset values:
  - SP = 0, so EMPTY=1, FULL=0, DEPTH_CNT=0
  - OVF_ERR=0, UNF_ERR=0
  - PC_DIN follows its inputs; it reads 0x000 for sel 1
  - Entry storage is not cleared; its contents are don't-care.
- RST asserted together with PUSH/POP: reset wins and no write occurs.

## Structure
- Shared package rat_pkg holds:
  - pc_src_t enum {PC_SRC_IMMED, PC_SRC_STACK, PC_SRC_INTR, PC_SRC_RSVD}
  - PC_W = 10
  - INTR_VECTOR = 10'h3FF
- One sub-module, return_stack_mem: DEPTH×PC_W register array, single write port, asynchronous read at address SP−1.
- The top level holds the SP counter, the flags and the output mux.

## Test plan
- Reset, then sel 1 with no pushes → PC_DIN=0x000, EMPTY=1, DEPTH_CNT=0, UNF_ERR=0.
- PC_COUNT=0x010, PUSH=1, sel 0, IMMED=0x200 → PC_DIN=0x200; next cycle DEPTH_CNT=1 and sel 1 gives PC_DIN=0x011. POP then gives EMPTY=1.
- PC_COUNT=0x3FF, PUSH=1 → stored entry reads 0x000 (wrap).
- 8 pushes of 0x001..0x008 → FULL=1. A 9th push leaves OVF_ERR=1, DEPTH_CNT=8, top still 0x008. Eight pops return 0x008 down to 0x001 in order.
- With 2 entries (top 0x055), PUSH+POP with PC_COUNT=0x0AA → PC_DIN=0x055 that cycle; next cycle top=0x0AB, DEPTH_CNT=2.
- Pop while EMPTY → UNF_ERR=1 and it stays set through later valid pushes. RST asserted mid-sequence with PUSH=1 → next cycle EMPTY=1, both error flags 0.
- Sel 2 → PC_DIN=0x3FF; sel 3 → PC_DIN=0x000.
